// File: rtl/instruction_loader.sv
// instruction_loader: assembles little-endian UART bytes into words and writes them to instruction memory
module instruction_loader #(
  parameter int MEM_SIZE = 64,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_Start,
  input  logic                   i_Rx_Done,
  input  logic [BYTE_WIDTH-1:0]  i_Rx_Byte,
  output logic                   o_Wr_En,
  output logic [ADDR_LENGTH-1:0] o_Wr_Addr,
  output logic [WORD_WIDTH-1:0]  o_Wr_Data,
  output logic                   o_Busy,
  output logic                   o_Load_Done,
  output logic                   o_Overflow,
  output logic [ADDR_LENGTH-1:0] o_Word_Count
);
  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;
  state_t state, next;
  logic [1:0] bcnt;
  logic [WORD_WIDTH-1:0] buffer;
  logic [ADDR_LENGTH-1:0] wcnt;
  logic ovf, halt, last, idle_like;
  assign halt = buffer == HALT_WORD;
  assign last = wcnt == ADDR_LENGTH'(MEM_SIZE - 1);
  assign idle_like = state == IDLE || state == DONE;
  always_comb begin
    next = state;
    if (idle_like)
      next = i_Start ? RECEIVE : state;
    else if (state == RECEIVE)
      next = (i_Rx_Done && &bcnt) ? WRITE : RECEIVE;
    else
      next = (halt || last) ? DONE : RECEIVE;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= next;
  // Internal counters run one cycle ahead; every output is a registered copy of them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bcnt <= '0;
      buffer <= '0;
      wcnt <= '0;
      ovf <= 1'b0;
      o_Wr_En <= 1'b0;
      o_Wr_Addr <= '0;
      o_Wr_Data <= '0;
      o_Busy <= 1'b0;
      o_Load_Done <= 1'b0;
      o_Overflow <= 1'b0;
      o_Word_Count <= '0;
    end else begin
      if (state == IDLE || (state == DONE && i_Start)) begin
        bcnt <= '0;
        wcnt <= '0;
        ovf <= 1'b0;
      end
      if ((state == RECEIVE || state == WRITE) && i_Rx_Done) begin
        buffer[int'(bcnt)*BYTE_WIDTH +: BYTE_WIDTH] <= i_Rx_Byte;
        bcnt <= bcnt + 2'd1;
      end
      if (state == WRITE) begin
        wcnt <= wcnt + 1'b1;
        ovf <= !halt && last;
        o_Wr_Addr <= wcnt;
        o_Wr_Data <= buffer;
      end
      o_Wr_En <= state == WRITE;
      o_Busy <= state == RECEIVE || state == WRITE;
      o_Load_Done <= state == DONE;
      o_Overflow <= ovf;
      o_Word_Count <= wcnt;
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed and randomized loads checked against a word-list model
module tb_instruction_loader;
  localparam int MEM = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  logic clk = 0, rst = 1, start = 0, rx_done = 0;
  logic [7:0] rx_byte = 0;
  logic wr_en, busy, done, ovf;
  logic [31:0] wr_addr, wr_data, wc;
  int checks = 0, errors = 0;
  logic [31:0] obs_addr[$], obs_data[$], exp_data[$];
  logic [7:0] tx[$];
  logic exp_done, exp_ovf;

  always #5 clk = ~clk;

  instruction_loader #(.MEM_SIZE(MEM)) dut (
    .i_clk(clk), .i_reset(rst), .i_Start(start), .i_Rx_Done(rx_done), .i_Rx_Byte(rx_byte),
    .o_Wr_En(wr_en), .o_Wr_Addr(wr_addr), .o_Wr_Data(wr_data), .o_Busy(busy),
    .o_Load_Done(done), .o_Overflow(ovf), .o_Word_Count(wc)
  );

  always @(negedge clk)
    if (wr_en) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
    end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx.push_back(w[8*i +: 8]);
  endtask

  task automatic do_start();
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic send(input int maxgap);
    foreach (tx[i]) begin
      rx_done = 1;
      rx_byte = tx[i];
      @(negedge clk) rx_done = 0;
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    end
  endtask

  // Expected result: consecutive 4-byte little-endian words until halt or full memory
  task automatic model();
    logic [31:0] w;
    exp_data.delete();
    exp_done = 0;
    exp_ovf = 0;
    for (int i = 0; i + 3 < tx.size() && !exp_done; i += 4) begin
      w = {tx[i+3], tx[i+2], tx[i+1], tx[i]};
      exp_data.push_back(w);
      if (w == HALT) exp_done = 1;
      else if (exp_data.size() == MEM) begin
        exp_done = 1;
        exp_ovf = 1;
      end
    end
  endtask

  task automatic verify(input string tag);
    repeat (4) @(negedge clk);
    model();
    check({tag, ".writes"}, obs_addr.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < obs_addr.size(); i++) begin
      check({tag, ".addr"}, obs_addr[i], i);
      check({tag, ".data"}, obs_data[i], exp_data[i]);
    end
    check({tag, ".done"}, done, exp_done);
    check({tag, ".ovf"}, ovf, exp_ovf);
    check({tag, ".count"}, wc, exp_data.size());
    check({tag, ".busy"}, busy, !exp_done);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wr_en"}, wr_en, 0);
    check({tag, ".wr_addr"}, wr_addr, 0);
    check({tag, ".wr_data"}, wr_data, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".ovf"}, ovf, 0);
    check({tag, ".count"}, wc, 0);
  endtask

  initial begin
    int n;
    logic [31:0] w;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 0;
    // single word, cycle-exact timing
    do_start();
    check("start.busy_early", busy, 0);
    tx = '{8'h13, 8'h00, 8'h00, 8'h00};
    foreach (tx[i]) begin
      rx_done = 1;
      rx_byte = tx[i];
      @(negedge clk);
      if (i == 0) check("start.busy", busy, 1);
    end
    rx_done = 0;
    check("w0.wr_en_early", wr_en, 0);
    @(negedge clk);
    check("w0.wr_en", wr_en, 1);
    check("w0.addr", wr_addr, 0);
    check("w0.data", wr_data, 32'h13);
    check("w0.count_old", wc, 0);
    @(negedge clk);
    check("w0.wr_en_end", wr_en, 0);
    check("w0.count", wc, 1);
    check("w0.busy", busy, 1);
    check("w0.done", done, 0);
    // reset in the middle of word 1
    tx = '{8'hAA, 8'hBB};
    send(0);
    #2 rst = 1;
    #1 check_zero("midreset");
    @(negedge clk) rst = 0;
    do_start();
    tx.delete();
    push_word(32'hCAFE0001);
    push_word(HALT);
    send(0);
    verify("after_reset");
    // back-to-back bytes through WRITE, halt on the last address
    do_start();
    tx.delete();
    push_word($urandom);
    push_word(32'h44332211);
    push_word($urandom);
    push_word(HALT);
    send(0);
    verify("halt");
    // overflow: five non-halt words, the fifth ignored
    do_start();
    tx.delete();
    for (int k = 0; k < 5; k++) push_word(32'h100 + k);
    send(1);
    verify("overflow");
    // restart from DONE clears status
    do_start();
    check("restart.done_lag", done, 1);
    @(negedge clk);
    check("restart.done", done, 0);
    check("restart.ovf", ovf, 0);
    check("restart.count", wc, 0);
    tx.delete();
    push_word(32'h00000001);
    push_word(HALT);
    send(0);
    verify("restart");
    // randomized loads
    for (int r = 0; r < 20; r++) begin
      do_start();
      tx.delete();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        w = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
        if (k == n - 1 && (n < MEM || (n == MEM && $urandom_range(0, 1) == 1))) w = HALT;
        push_word(w);
      end
      send($urandom_range(0, 2));
      verify($sformatf("rand%0d", r));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
